// File: rtl/alu_issue.sv
// Decode/issue stage for RV32I OP, OP-IMM, LUI and AUIPC with a RAW scoreboard (no forwarding).
// Optional build macro ALU_ISSUE_ILLEGAL_EN: flag unsupported or malformed encodings on o_illegal.
module alu_issue #(
  parameter int HAZ_DEPTH = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [4:0]  o_rd,
  output logic        o_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'h0,
    ALU_SUB    = 4'h1,
    ALU_SLT    = 4'h2,
    ALU_SLTU   = 4'h3,
    ALU_XOR    = 4'h4,
    ALU_OR     = 4'h5,
    ALU_AND    = 4'h6,
    ALU_SLL    = 4'h7,
    ALU_SRL    = 4'h8,
    ALU_SRA    = 4'h9,
    ALU_PASS_B = 4'hA
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // alt selects SUB/SRA; callers only raise it where the encoding allows.
  function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode     = i_instr[6:0];
  assign rd         = i_instr[11:7];
  assign funct3     = i_instr[14:12];
  assign rs1        = i_instr[19:15];
  assign rs2        = i_instr[24:20];
  assign funct7     = i_instr[31:25];
  assign o_rs1_addr = rs1;
  assign o_rs2_addr = rs2;

  logic        dec_known;
  logic        dec_legal;
  logic        dec_use_rs1;
  logic        dec_use_rs2;
  logic        dec_writes;
  alu_op_e     dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;

  always_comb begin
    dec_known   = 1'b0;
    dec_legal   = 1'b1;
    dec_use_rs1 = 1'b0;
    dec_use_rs2 = 1'b0;
    dec_writes  = 1'b0;
    dec_op      = ALU_ADD;
    dec_a       = '0;
    dec_b       = '0;
    case (opcode)
      OPC_OP: begin
        dec_known   = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_use_rs2 = 1'b1;
        dec_writes  = 1'b1;
        dec_op      = funct3_op(funct3, funct7[5]);
        dec_a       = i_rs1_data;
        dec_b       = i_rs2_data;
`ifdef ALU_ISSUE_ILLEGAL_EN
        dec_legal   = (funct7 == 7'h00) ||
                      ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`endif
      end
      OPC_OP_IMM: begin
        dec_known   = 1'b1;
        dec_use_rs1 = 1'b1;
        dec_writes  = 1'b1;
        // ADDI never becomes SUB; only SRAI honours bit 30.
        dec_op      = funct3_op(funct3, i_instr[30] & (funct3 == 3'b101));
        dec_a       = i_rs1_data;
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec_b = {27'b0, i_instr[24:20]};
        end else begin
          dec_b = {{20{i_instr[31]}}, i_instr[31:20]};
        end
`ifdef ALU_ISSUE_ILLEGAL_EN
        if (funct3 == 3'b001) begin
          dec_legal = (funct7 == 7'h00);
        end else if (funct3 == 3'b101) begin
          dec_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        end
`endif
      end
      OPC_LUI: begin
        dec_known  = 1'b1;
        dec_writes = 1'b1;
        dec_op     = ALU_PASS_B;
        dec_b      = {i_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec_known  = 1'b1;
        dec_writes = 1'b1;
        dec_op     = ALU_ADD;
        dec_a      = i_pc;
        dec_b      = {i_instr[31:12], 12'b0};
      end
      default: ;
    endcase
  end

  // Scoreboard: slot 0 is EX, slot HAZ_DEPTH-1 is WB.
  logic [HAZ_DEPTH-1:0]      sb_v_q;
  logic [HAZ_DEPTH-1:0]      sb_v_d;
  logic [HAZ_DEPTH-1:0][4:0] sb_rd_q;
  logic [HAZ_DEPTH-1:0][4:0] sb_rd_d;

  logic hit_rs1;
  logic hit_rs2;
  logic hazard;
  logic accept;
  logic issue;

  always_comb begin
    hit_rs1 = 1'b0;
    hit_rs2 = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v_q[i] && (sb_rd_q[i] == rs1)) hit_rs1 = 1'b1;
      if (sb_v_q[i] && (sb_rd_q[i] == rs2)) hit_rs2 = 1'b1;
    end
  end

  assign hazard  = i_valid & ((dec_use_rs1 & (rs1 != 5'd0) & hit_rs1) |
                              (dec_use_rs2 & (rs2 != 5'd0) & hit_rs2));
  assign o_ready = ~i_rst & ~i_flush & ~hazard;
  assign accept  = i_valid & o_ready;
  assign issue   = accept & dec_known & dec_legal;

  always_comb begin
    sb_v_d     = '0;
    sb_rd_d    = '0;
    sb_v_d[0]  = issue & dec_writes & (rd != 5'd0);
    sb_rd_d[0] = sb_v_d[0] ? rd : 5'd0;
    for (int i = 1; i < HAZ_DEPTH; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sb_v_q  <= '0;
      sb_rd_q <= '0;
    end else begin
      sb_v_q  <= sb_v_d;
      sb_rd_q <= sb_rd_d;
    end
  end

  logic        valid_q, valid_d;
  alu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;

  // Anything not issued (stall, flush, idle, unsupported) becomes an all-zero bubble.
  always_comb begin
    valid_d = 1'b0;
    op_d    = ALU_ADD;
    a_d     = '0;
    b_d     = '0;
    rd_d    = '0;
    if (issue) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      a_d     = dec_a;
      b_d     = dec_b;
      rd_d    = rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      op_q    <= ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_alu_op    = op_q;
  assign o_operand_a = a_q;
  assign o_operand_b = b_q;
  assign o_rd        = rd_q;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic illegal_q;
  logic illegal_d;

  assign illegal_d = accept & ~(dec_known & dec_legal);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign o_illegal = illegal_q;
`else
  assign o_illegal = 1'b0;
`endif

endmodule
